// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: write-port controller for the branch target buffer.
// Merges taken-branch (EX) and jump (ID) updates onto one BTB write port
// with round-robin arbitration. On flush it sweeps every row with an
// invalidate write and raises flush_busy while the sweep runs.
module btb_update_ctrl #(
    parameter int LOWER = 5
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                br_valid,
    output logic                br_ready,
    input  logic [63:0]         br_pc,
    input  logic [63:0]         br_target,
    input  logic                jmp_valid,
    output logic                jmp_ready,
    input  logic [63:0]         jmp_pc,
    input  logic [63:0]         jmp_target,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic                wr_en,
    output logic [LOWER-1:0]    wr_index,
    output logic [63-LOWER:0]   wr_tag,
    output logic [63:0]         wr_target,
    output logic                wr_valid_bit
);

    localparam int TAGW = 64 - LOWER;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Sweep counter: the row index currently presented on the write port.
    logic [LOWER-1:0] cnt, cnt_nxt;

    // Round-robin pointer: 0 = branch wins a contested grant, 1 = jump wins.
    logic ptr, ptr_nxt;

    // Holding registers, one per source.
    logic             br_held;
    logic [TAGW-1:0]  br_tag_q;
    logic [LOWER-1:0] br_idx_q;
    logic [63:0]      br_tgt_q;
    logic             jmp_held;
    logic [TAGW-1:0]  jmp_tag_q;
    logic [LOWER-1:0] jmp_idx_q;
    logic [63:0]      jmp_tgt_q;

    // Next values of the registered write-port outputs.
    logic             wr_en_nxt;
    logic [LOWER-1:0] wr_index_nxt;
    logic [TAGW-1:0]  wr_tag_nxt;
    logic [63:0]      wr_target_nxt;
    logic             wr_valid_bit_nxt;

    logic sweep_last;
    logic arb_edge;
    logic br_grant;
    logic jmp_grant;
    logic both_held;
    logic br_load;
    logic jmp_load;

    // The last sweep cycle doubles as an arbitration edge so a held entry
    // is written in the cycle right after the final invalidate.
    assign sweep_last = (state == FLUSH) && (cnt == {LOWER{1'b1}});
    assign arb_edge   = !flush_req && ((state == RUN) || sweep_last);
    assign both_held  = br_held && jmp_held;

    // Round-robin grant; flush_req suppresses every grant on its edge.
    assign br_grant  = arb_edge && br_held  && (!jmp_held || !ptr);
    assign jmp_grant = arb_edge && jmp_held && (!br_held  ||  ptr);

    // A source accepts a new update when its slot is empty or is being
    // drained this edge; independent of valid, and closed during a sweep.
    assign br_ready  = (state == RUN) && (!br_held  || br_grant);
    assign jmp_ready = (state == RUN) && (!jmp_held || jmp_grant);

    assign br_load  = br_valid  && br_ready;
    assign jmp_load = jmp_valid && jmp_ready;

    // flush_busy covers exactly the cycles in which FLUSH is the state.
    assign flush_busy = (state == FLUSH);

    // Next-state, sweep counter, arbitration pointer and write-port values.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt        = state;
        cnt_nxt          = cnt;
        ptr_nxt          = ptr;
        wr_en_nxt        = 1'b0;
        wr_index_nxt     = wr_index;
        wr_tag_nxt       = wr_tag;
        wr_target_nxt    = wr_target;
        wr_valid_bit_nxt = wr_valid_bit;

        if (flush_req) begin
            // Start or restart the sweep at row 0.
            state_nxt        = FLUSH;
            cnt_nxt          = '0;
            wr_en_nxt        = 1'b1;
            wr_index_nxt     = '0;
            wr_tag_nxt       = '0;
            wr_target_nxt    = '0;
            wr_valid_bit_nxt = 1'b0;
        end else if ((state == FLUSH) && !sweep_last) begin
            cnt_nxt          = cnt + LOWER'(1);
            wr_en_nxt        = 1'b1;
            wr_index_nxt     = cnt + LOWER'(1);
            wr_tag_nxt       = '0;
            wr_target_nxt    = '0;
            wr_valid_bit_nxt = 1'b0;
        end else begin
            // RUN, or leaving FLUSH after the last row: serve held entries.
            state_nxt = RUN;
            cnt_nxt   = '0;
            if (br_grant) begin
                wr_en_nxt        = 1'b1;
                wr_index_nxt     = br_idx_q;
                wr_tag_nxt       = br_tag_q;
                wr_target_nxt    = br_tgt_q;
                wr_valid_bit_nxt = 1'b1;
            end else if (jmp_grant) begin
                wr_en_nxt        = 1'b1;
                wr_index_nxt     = jmp_idx_q;
                wr_tag_nxt       = jmp_tag_q;
                wr_target_nxt    = jmp_tgt_q;
                wr_valid_bit_nxt = 1'b1;
            end
            // Contested grant: the loser gets priority next time.
            if (both_held) begin
                ptr_nxt = br_grant;
            end
        end
    end

    // State register, sweep counter, pointer and registered write port.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state        <= RUN;
            cnt          <= '0;
            ptr          <= 1'b0;
            wr_en        <= 1'b0;
            wr_index     <= '0;
            wr_tag       <= '0;
            wr_target    <= '0;
            wr_valid_bit <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            ptr          <= ptr_nxt;
            wr_en        <= wr_en_nxt;
            wr_index     <= wr_index_nxt;
            wr_tag       <= wr_tag_nxt;
            wr_target    <= wr_target_nxt;
            wr_valid_bit <= wr_valid_bit_nxt;
        end
    end

    // Branch holding register: drained on grant, refilled on handshake.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            br_held  <= 1'b0;
            br_tag_q <= '0;
            br_idx_q <= '0;
            br_tgt_q <= '0;
        end else begin
            if (br_grant) begin
                br_held <= 1'b0;
            end
            if (br_load) begin
                br_held  <= 1'b1;
                br_tag_q <= br_pc[63:LOWER];
                br_idx_q <= br_pc[LOWER-1:0];
                br_tgt_q <= br_target;
            end
        end
    end

    // Jump holding register: drained on grant, refilled on handshake.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            jmp_held  <= 1'b0;
            jmp_tag_q <= '0;
            jmp_idx_q <= '0;
            jmp_tgt_q <= '0;
        end else begin
            if (jmp_grant) begin
                jmp_held <= 1'b0;
            end
            if (jmp_load) begin
                jmp_held  <= 1'b1;
                jmp_tag_q <= jmp_pc[63:LOWER];
                jmp_idx_q <= jmp_pc[LOWER-1:0];
                jmp_tgt_q <= jmp_target;
            end
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Testbench for btb_update_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all checked each cycle against a
// behavioural model of the write-port schedule.
module tb_btb_update_ctrl;

    localparam int LOWER = 5;
    localparam int ROWS  = 1 << LOWER;

    logic                clk = 1'b0;
    logic                arst;
    logic                br_valid, jmp_valid, flush_req;
    logic [63:0]         br_pc, br_target, jmp_pc, jmp_target;
    logic                br_ready, jmp_ready, flush_busy;
    logic                wr_en, wr_valid_bit;
    logic [LOWER-1:0]    wr_index;
    logic [63-LOWER:0]   wr_tag;
    logic [63:0]         wr_target;

    int n_vec = 0;
    int n_err = 0;

    btb_update_ctrl #(.LOWER(LOWER)) dut (
        .clk(clk), .arst(arst),
        .br_valid(br_valid), .br_ready(br_ready), .br_pc(br_pc), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_ready(jmp_ready), .jmp_pc(jmp_pc), .jmp_target(jmp_target),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .wr_en(wr_en), .wr_index(wr_index), .wr_tag(wr_tag),
        .wr_target(wr_target), .wr_valid_bit(wr_valid_bit)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    typedef struct { logic [63:0] pc; logic [63:0] tgt; } upd_t;

    bit   m_bh, m_jh;          // entry waiting per source
    upd_t m_b, m_j;
    bit   m_jmp_first;         // who wins the next contested grant
    int   m_pos;               // row being invalidated, -1 when not sweeping
    bit   e_en, e_vb;
    logic [63:0] e_idx, e_tag, e_tgt;

    task automatic model_reset();
        m_bh = 0; m_jh = 0; m_jmp_first = 0; m_pos = -1;
        e_en = 0; e_vb = 0; e_idx = 0; e_tag = 0; e_tgt = 0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("wr_en", 64'(wr_en), 64'(e_en));
        check("flush_busy", 64'(flush_busy), 64'(m_pos >= 0));
        check("wr_index", 64'(wr_index), e_idx);
        check("wr_tag", 64'(wr_tag), e_tag);
        check("wr_target", wr_target, e_tgt);
        if (e_en) check("wr_valid_bit", 64'(wr_valid_bit), 64'(e_vb));
    endtask

    // One clock cycle: drive inputs, check readys, advance the model, then
    // check the registered outputs on the following falling edge.
    task automatic step(input bit bv, input logic [63:0] bp, input logic [63:0] bt,
                        input bit jv, input logic [63:0] jp, input logic [63:0] jt,
                        input bit fr);
        bit sweeping, arb, gb, gj, rb, rj;
        br_valid = bv; br_pc = bp; br_target = bt;
        jmp_valid = jv; jmp_pc = jp; jmp_target = jt;
        flush_req = fr;
        #1;
        sweeping = (m_pos >= 0);
        arb = !fr && (!sweeping || m_pos == ROWS - 1);
        gb  = arb && m_bh && (!m_jh || !m_jmp_first);
        gj  = arb && m_jh && (!m_bh ||  m_jmp_first);
        rb  = !sweeping && (!m_bh || gb);
        rj  = !sweeping && (!m_jh || gj);
        check("br_ready", 64'(br_ready), 64'(rb));
        check("jmp_ready", 64'(jmp_ready), 64'(rj));

        if (fr) begin
            m_pos = 0;
            e_en = 1; e_vb = 0; e_idx = 0; e_tag = 0; e_tgt = 0;
        end else if (sweeping && m_pos < ROWS - 1) begin
            m_pos++;
            e_en = 1; e_vb = 0; e_idx = 64'(m_pos); e_tag = 0; e_tgt = 0;
        end else begin
            m_pos = -1;
            e_en = 0;
            if (gb || gj) begin
                upd_t w;
                w = gb ? m_b : m_j;
                e_en = 1; e_vb = 1;
                e_idx = w.pc % ROWS;
                e_tag = w.pc >> LOWER;
                e_tgt = w.tgt;
            end
            if (m_bh && m_jh) m_jmp_first = gb;
        end
        if (gb) m_bh = 0;
        if (gj) m_jh = 0;
        if (bv && rb) begin m_bh = 1; m_b.pc = bp; m_b.tgt = bt; end
        if (jv && rj) begin m_jh = 1; m_j.pc = jp; m_j.tgt = jt; end

        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wr_count;
        arst = 1'b1;
        br_valid = 0; jmp_valid = 0; flush_req = 0;
        br_pc = 0; br_target = 0; jmp_pc = 0; jmp_target = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;

        // Reset state, literal.
        check("reset wr_en", 64'(wr_en), 0);
        check("reset flush_busy", 64'(flush_busy), 0);
        check("reset br_ready", 64'(br_ready), 1);
        check("reset jmp_ready", 64'(jmp_ready), 1);
        check_outputs();

        // Single branch update: pc 0x44 -> row 4, tag 2.
        wr_count = 0;
        step(1, 64'h44, 64'h100, 0, 0, 0, 0);
        wr_count += int'(wr_en);
        idle();
        check("single wr_en", 64'(wr_en), 1);
        check("single wr_index", 64'(wr_index), 4);
        check("single wr_tag", 64'(wr_tag), 2);
        check("single wr_target", wr_target, 64'h100);
        check("single wr_valid_bit", 64'(wr_valid_bit), 1);
        wr_count += int'(wr_en);
        for (int i = 0; i < 3; i++) begin idle(); wr_count += int'(wr_en); end
        check("single write count", 64'(wr_count), 1);

        // Contention: branch first, then jump; then jump first, then branch.
        step(1, 64'h20, 64'hA0, 1, 64'h40, 64'hB0, 0);
        idle();
        check("rr1 first tag", 64'(wr_tag), 1);
        check("rr1 first target", wr_target, 64'hA0);
        idle();
        check("rr1 second tag", 64'(wr_tag), 2);
        check("rr1 second target", wr_target, 64'hB0);
        idle();
        step(1, 64'h20, 64'hA1, 1, 64'h40, 64'hB1, 0);
        idle();
        check("rr2 first target", wr_target, 64'hB1);
        idle();
        check("rr2 second target", wr_target, 64'hA1);
        idle();

        // Full sweep from a one-cycle flush_req.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < ROWS; i++) begin
            check("sweep wr_en", 64'(wr_en), 1);
            check("sweep wr_index", 64'(wr_index), 64'(i));
            check("sweep wr_valid_bit", 64'(wr_valid_bit), 0);
            check("sweep flush_busy", 64'(flush_busy), 1);
            check("sweep br_ready", 64'(br_ready), 0);
            check("sweep jmp_ready", 64'(jmp_ready), 0);
            idle();
        end
        check("sweep end flush_busy", 64'(flush_busy), 0);
        check("sweep end wr_en", 64'(wr_en), 0);

        // Branch held across a sweep: written right after row 31.
        step(1, 64'h1234, 64'h5678, 0, 0, 0, 1);
        for (int i = 0; i < ROWS - 1; i++) idle();
        check("held last row", 64'(wr_index), 64'(ROWS - 1));
        idle();
        check("held after sweep wr_en", 64'(wr_en), 1);
        check("held after sweep valid", 64'(wr_valid_bit), 1);
        check("held after sweep index", 64'(wr_index), 64'h14);
        check("held after sweep target", wr_target, 64'h5678);
        idle();

        // Asynchronous reset in the middle of a sweep.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) idle();
        check("pre-reset wr_index", 64'(wr_index), 10);
        #2 arst = 1'b1;
        #1;
        check("arst wr_en", 64'(wr_en), 0);
        check("arst flush_busy", 64'(flush_busy), 0);
        check("arst br_ready", 64'(br_ready), 1);
        check("arst jmp_ready", 64'(jmp_ready), 1);
        model_reset();
        #1 arst = 1'b0;
        for (int i = 0; i < 4; i++) idle();

        // Back-to-back branch stream, no contention.
        for (int i = 0; i < 4; i++) begin
            step(1, 64'(4 * i), 64'(64'h200 + i), 0, 0, 0, 0);
            check("stream br_ready", 64'(br_ready), 1);
            if (i > 0) check("stream wr_index", 64'(wr_index), 64'(4 * (i - 1)));
        end
        idle();
        check("stream last wr_index", 64'(wr_index), 12);
        idle();

        // Randomized traffic with occasional flushes and index collisions.
        for (int n = 0; n < 2000; n++) begin
            logic [63:0] bp, jp;
            bp = {$urandom(), $urandom()};
            jp = {$urandom(), $urandom()};
            if ($urandom_range(3) == 0) jp[LOWER-1:0] = bp[LOWER-1:0];
            step($urandom_range(1), bp, {$urandom(), $urandom()},
                 $urandom_range(1), jp, {$urandom(), $urandom()},
                 $urandom_range(59) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
